// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch front end. Owns the PC, issues one read per cycle to a
//   synchronous inst SRAM (1-cycle read latency), buffers returned words in a
//   small FIFO and presents {fs_pc, fs_inst} downstream with a valid/allow-in
//   handshake. Branch/jump redirects from the core flush everything in flight.
//
//   Ports
//     clk, resetn          clock; synchronous active-low reset
//     inst_sram_*          read port to inst SRAM (we/wdata tied 0)
//     br_taken, br_target  redirect pulse and target from the core
//     ds_allow_in          downstream accepts this cycle
//     fs_to_ds_valid       {fs_pc, fs_inst} valid
//     fs_adef              fetch address error flag
//
//   Configuration macro FETCH_ADEF_EN: when defined, a misaligned fetch
//   address is still issued, but its entry is presented with fs_adef=1 and
//   fs_inst=0, and fetch halts until the next redirect. When undefined,
//   fs_adef is tied 0 and the low address bits are ignored.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allow_in,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_pc_q   [BUF_DEPTH];
  logic [31:0]   buf_pc_d   [BUF_DEPTH];
  logic [31:0]   buf_inst_q [BUF_DEPTH];
  logic [31:0]   buf_inst_d [BUF_DEPTH];

  logic          buf_empty, pop, pop_buf, push, room, issue;
  logic [31:0]   rsp_inst, pres_pc, pres_inst;
  logic          halt;

`ifdef FETCH_ADEF_EN
  logic                 rsp_adef_q, rsp_adef_d;
  logic                 halt_q, halt_d;
  logic [BUF_DEPTH-1:0] buf_adef_q, buf_adef_d;
  logic                 pres_adef;
`endif

  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;

  always_comb begin
    pc_d       = pc_q;
    rsp_vld_d  = 1'b0;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
`ifdef FETCH_ADEF_EN
    rsp_adef_d = rsp_adef_q;
    halt_d     = halt_q;
    buf_adef_d = buf_adef_q;
    halt       = halt_q;
    // An erroring fetch returns no usable word.
    rsp_inst   = rsp_adef_q ? 32'h0 : inst_sram_rdata;
`else
    halt       = 1'b0;
    rsp_inst   = inst_sram_rdata;
`endif

    // Present the FIFO head if any, else the response arriving this cycle.
    buf_empty = (cnt_q == '0);
    pres_pc   = buf_empty ? rsp_pc_q : buf_pc_q[rd_ptr_q];
    pres_inst = buf_empty ? rsp_inst : buf_inst_q[rd_ptr_q];
`ifdef FETCH_ADEF_EN
    pres_adef = buf_empty ? rsp_adef_q : buf_adef_q[rd_ptr_q];
`endif

    fs_to_ds_valid = resetn & ~br_taken & (~buf_empty | rsp_vld_q);
    pop            = fs_to_ds_valid & ds_allow_in;
    pop_buf        = pop & ~buf_empty;
    // The arriving response goes to the FIFO unless it was handed over by bypass.
    push           = rsp_vld_q & ~br_taken & ~(buf_empty & pop);

    // Reserve space for the in-flight response so the FIFO never overflows.
    room = ({1'b0, cnt_q} + (CW+1)'(rsp_vld_q)) <
           ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop));

    issue          = resetn & (br_taken | (room & ~halt));
    inst_sram_en   = issue;
    inst_sram_addr = br_taken ? br_target : pc_q;

    if (issue) begin
      pc_d      = inst_sram_addr + 32'd4;
      rsp_vld_d = 1'b1;
      rsp_pc_d  = inst_sram_addr;
`ifdef FETCH_ADEF_EN
      rsp_adef_d = |inst_sram_addr[1:0];
      halt_d     = |inst_sram_addr[1:0];
`endif
    end

    if (br_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]   = rsp_pc_q;
        buf_inst_d[wr_ptr_q] = rsp_inst;
`ifdef FETCH_ADEF_EN
        buf_adef_d[wr_ptr_q] = rsp_adef_q;
`endif
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_buf) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop_buf);
    end

    fs_pc   = pres_pc;
    fs_inst = pres_inst;
`ifdef FETCH_ADEF_EN
    fs_adef = fs_to_ds_valid & pres_adef;
`else
    fs_adef = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      rsp_vld_q <= 1'b0;
      rsp_pc_q  <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
`ifdef FETCH_ADEF_EN
      rsp_adef_q <= 1'b0;
      halt_q     <= 1'b0;
      buf_adef_q <= '0;
`endif
    end else begin
      pc_q      <= pc_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_pc_q  <= rsp_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
`ifdef FETCH_ADEF_EN
      rsp_adef_q <= rsp_adef_d;
      halt_q     <= halt_d;
      buf_adef_q <= buf_adef_d;
`endif
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    buf_pc_q   <= buf_pc_d;
    buf_inst_q <= buf_inst_d;
  end

endmodule
